// File: rtl/exp2_pkg.sv
// exp2_unit shared definitions: FSM states, special-case codes,
// Q-format widths, float constants and the 2^(k/16) base table.
package exp2_pkg;

    localparam int K_W    = 4;
    localparam int SEG_W  = 19;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = 24;
    localparam int FIX_W  = 31;
    localparam int PROD_W = MAN_W + SEG_W;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;
    localparam logic [31:0] ONE  = 32'h3F80_0000;

    localparam logic [7:0] BIAS    = ONE[30:23];
    localparam logic [7:0] SAT_EXP = 8'd134;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_LOOKUP,
        S_MAC,
        S_PACK,
        S_HOLD
    } state_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_OVF,
        SP_UNF
    } spec_e;

    // 2^(k/16) in Q1.23, rounded to nearest; entry 16 is 2.0
    localparam logic [24:0] BASE [17] = '{
        25'd8388608,  25'd8760003,  25'd9147842,  25'd9552851,
        25'd9975792,  25'd10417458, 25'd10878679, 25'd11360319,
        25'd11863283, 25'd12388516, 25'd12937002, 25'd13509772,
        25'd14107901, 25'd14732511, 25'd15384775, 25'd16065917,
        25'd16777216
    };

endpackage

// File: rtl/exp2_lut.sv
// exp2_unit segment ROM: fraction bits of base[k] and the
// slope base[k+1]-base[k] for the linear interpolation.
module exp2_lut
    import exp2_pkg::*;
(
    input  logic [K_W-1:0]    k_i,
    output logic [FRAC_W-1:0] base_frac_o,
    output logic [MAN_W-1:0]  slope_o
);

    logic [K_W:0] k_lo;
    logic [K_W:0] k_hi;

    assign k_lo = {1'b0, k_i};
    assign k_hi = k_lo + 5'd1;

    // base[k] always lies in [1,2): the integer bit is implied
    assign base_frac_o = FRAC_W'(BASE[k_lo]);
    assign slope_o     = MAN_W'(BASE[k_hi] - BASE[k_lo]);

endmodule

// File: rtl/exp2_unit.sv
// 2^t for IEEE-754 single t via 16-segment linear interpolation.
// Define EXP2_ROUND_EN to round the interpolation term to nearest.
module exp2_unit
    import exp2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        ovf,
    output logic        unf
);

    state_e state_q, state_d;

    logic [31:0]       op_q;
    spec_e             spec_q, spec_d;
    logic [7:0]        n_q, n_d;
    logic [FRAC_W-1:0] f_q, f_d;
    logic [FRAC_W-1:0] bfrac_q;
    logic [MAN_W-1:0]  slope_q;
    logic [FRAC_W-1:0] mfrac_q, mfrac_d;
    logic [31:0]       data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [FRAC_W-1:0] lut_base;
    logic [MAN_W-1:0]  lut_slope;

    logic              sgn;
    logic [7:0]        ex;
    logic [MAN_W-1:0]  man;
    logic [FIX_W-1:0]  mag;
    logic [FIX_W-1:0]  fx;

    logic [PROD_W-1:0] prod;
    logic [MAN_W-1:0]  term;
    logic [MAN_W-1:0]  sum;

    logic signed [8:0] ebias;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = data_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (in_valid) state_d = S_UNPACK;
            S_UNPACK: state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_MAC;
            S_MAC:    state_d = S_PACK;
            S_PACK:   state_d = S_HOLD;
            S_HOLD:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign sgn = op_q[31];
    assign ex  = op_q[30:23];
    assign man = {1'b1, op_q[22:0]};

    // signed Q8.23: n is the floor, f the non-negative remainder
    always_comb begin
        mag = '0;
        if (ex == 8'd0) begin
            mag = '0;
        end else if (ex >= BIAS) begin
            mag = FIX_W'(man) << (ex - BIAS);
        end else if ((BIAS - ex) < 8'd24) begin
            mag = FIX_W'(man >> (BIAS - ex));
        end
        fx  = sgn ? -mag : mag;
        n_d = fx[FIX_W-1:FRAC_W];
        f_d = fx[FRAC_W-1:0];
        spec_d = SP_NONE;
        if (ex == 8'hFF && op_q[22:0] != '0) begin
            spec_d = SP_NAN;
        end else if (ex >= SAT_EXP) begin
            spec_d = sgn ? SP_UNF : SP_OVF;
        end
    end

    exp2_lut u_lut (
        .k_i         (f_q[FRAC_W-1 -: K_W]),
        .base_frac_o (lut_base),
        .slope_o     (lut_slope)
    );

    always_comb begin
        prod = PROD_W'(slope_q) * PROD_W'(f_q[SEG_W-1:0]);
`ifdef EXP2_ROUND_EN
        term = MAN_W'((prod + (PROD_W'(1) << (SEG_W - 1))) >> SEG_W);
`else
        term = MAN_W'(prod >> SEG_W);
`endif
        sum = {1'b0, bfrac_q} + term;
        // a carry out means m reached 2.0; clamp just below it
        mfrac_d = sum[MAN_W-1] ? '1 : sum[FRAC_W-1:0];
    end

    always_comb begin
        ebias  = $signed({n_q[7], n_q}) + $signed({1'b0, BIAS});
        data_d = {1'b0, ebias[7:0], mfrac_q};
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        unique case (spec_q)
            SP_NAN: data_d = QNAN;
            SP_OVF: begin
                data_d = PINF;
                ovf_d  = 1'b1;
            end
            SP_UNF: begin
                data_d = '0;
                unf_d  = 1'b1;
            end
            SP_NONE: begin
                if (ebias <= 9'sd0) begin
                    data_d = '0;
                    unf_d  = 1'b1;
                end else if (ebias >= 9'sd255) begin
                    data_d = PINF;
                    ovf_d  = 1'b1;
                end
            end
            default: data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            spec_q  <= SP_NONE;
            n_q     <= '0;
            f_q     <= '0;
            bfrac_q <= '0;
            slope_q <= '0;
            mfrac_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && in_valid) begin
                op_q <= in_data;
            end
            if (state_q == S_UNPACK) begin
                n_q    <= n_d;
                f_q    <= f_d;
                spec_q <= spec_d;
            end
            if (state_q == S_LOOKUP) begin
                bfrac_q <= lut_base;
                slope_q <= lut_slope;
            end
            if (state_q == S_MAC) begin
                mfrac_q <= mfrac_d;
            end
            if (state_q == S_PACK) begin
                data_q <= data_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end
    end

endmodule

// File: tb/tb_exp2_unit.sv
// exp2_unit bench: directed vectors with literal results plus a
// real-valued 2^t model checked on every cycle out_valid is high.
module tb_exp2_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        ovf;
    logic        unf;

    int checks = 0;
    int errors = 0;

    logic [31:0] pend_q[$];

    always #5 clk = ~clk;

    exp2_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .unf       (unf)
    );

    task automatic chk(input string nm, input logic [33:0] got,
                       input logic [33:0] xp);
        checks++;
        if (got !== xp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, xp);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    // result rules stated directly in terms of the real value of t
    task automatic check_model(input logic [31:0] t);
        logic [7:0] e;
        real tr, xv, got, rel;
        e = t[30:23];
        if (e == 8'hFF && t[22:0] != 23'd0) begin
            chk("model_nan", {out_data, ovf, unf}, {32'h7FC00000, 2'b00});
        end else if (e >= 8'd134) begin
            chk("model_sat", {out_data, ovf, unf},
                t[31] ? {32'h0, 2'b01} : {32'h7F800000, 2'b10});
        end else begin
            tr = f2r(t);
            if ($floor(tr) < -126.0) begin
                chk("model_unf", {out_data, ovf, unf}, {32'h0, 2'b01});
            end else begin
                chk("model_flags", {31'd0, out_data[31], ovf, unf}, 34'd0);
                xv  = 2.0 ** tr;
                got = f2r(out_data);
                rel = (got > xv) ? (got - xv) / xv : (xv - got) / xv;
                checks++;
                if (rel > 3.0e-4) begin
                    errors++;
                    $display("FAIL model_rel: t=%h got %h rel err %e limit 3e-4",
                             t, out_data, rel);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
        end else begin
            if (out_valid && out_ready && pend_q.size() > 0)
                void'(pend_q.pop_front());
            if (in_valid && in_ready)
                pend_q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (pend_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL model_queue: out_valid with no pending operand");
            end else begin
                check_model(pend_q[0]);
            end
        end
    end

    task automatic run_op(input logic [31:0] t, input logic [31:0] xd,
                          input logic [1:0] xf, input bit lit);
        int n;
        int lat;
        @(negedge clk);
        in_data  = t;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 34'(in_ready), 34'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 34'(lat), 34'd4);
        if (lit) begin
            chk("lit_data", {2'b00, out_data}, {2'b00, xd});
            chk("lit_flags", {32'h0, ovf, unf}, {32'h0, xf});
        end
        if (out_ready) @(negedge clk);
    endtask

    localparam int NV = 15;
    logic [31:0] v_in [NV] = '{
        32'h00000000, 32'h3F800000, 32'hBF800000, 32'h40200000,
        32'hBF000000, 32'h3F000000, 32'h3E800000, 32'h43000000,
        32'hC2FE0000, 32'h7FC00000, 32'h7F800000, 32'hFF800000,
        32'h42FE0000, 32'h80000000, 32'hBF400000
    };
    logic [31:0] v_out [NV] = '{
        32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40B504F3,
        32'h3F3504F3, 32'h3FB504F3, 32'h3F9837F0, 32'h7F800000,
        32'h00000000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
        32'h7F000000, 32'h3F800000, 32'h3F1837F0
    };
    logic [1:0] v_fl [NV] = '{
        2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
        2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00
    };

    initial begin
        logic [31:0] held;
        logic [31:0] r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_hs", {32'h0, in_ready, out_valid}, {32'h0, 2'b10});
        chk("reset_data", {2'b00, out_data}, 34'd0);
        chk("reset_flags", {32'h0, ovf, unf}, 34'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op(v_in[i], v_out[i], v_fl[i], 1'b1);

        out_ready = 1'b0;
        run_op(32'h40000000, 32'h40800000, 2'b00, 1'b1);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                in_data  = 32'h3F800000;
            end
            chk("bp_data", {2'b00, out_data}, {2'b00, held});
            chk("bp_hs", {32'h0, in_ready, out_valid}, {32'h0, 2'b01});
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {32'h0, in_ready, out_valid}, {32'h0, 2'b10});

        @(negedge clk);
        in_data  = 32'h3F800000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mac_busy", {32'h0, in_ready, out_valid}, 34'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mac_rst", {out_data, in_ready, out_valid}, {32'h0, 2'b10});
        rst = 1'b0;
        run_op(32'h3F800000, 32'h40000000, 2'b00, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            r = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 133)),
                 23'($urandom)};
            if (i % 50 == 0) r[30:23] = 8'd0;
            run_op(r, 32'h0, 2'b00, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
